gyro_src_arb: RTL and testbench
===============================

GYRO_SRC_ARB -- requirements
Module: gyro_src_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of 48-bit stream requesters (legal 2..4).
REQ-002 SHALL have parameter MAX_BEATS, default 16384, maximum beats per frame (0x18000 bytes / 6 bytes per beat).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, permits new grants.
REQ-007 SHALL have port s_axis_vld, input, NUM_SRC, per-source valid.
REQ-008 SHALL have port s_axis_data, input, NUM_SRC*48, source i at bits [48i+47:48i].
REQ-009 SHALL have port s_axis_strb, input, NUM_SRC*6, source i at bits [6i+5:6i].
REQ-010 SHALL have port s_axis_last, input, NUM_SRC, per-source end of frame.
REQ-011 SHALL have port s_axis_rdy, output, NUM_SRC, per-source ready.
REQ-012 SHALL have port m_axis_vld / m_axis_data / m_axis_strb / m_axis_last, output, 1/48/6/1, stream to the 48-to-32 packer.
REQ-013 SHALL have port m_axis_rdy, input, 1, downstream ready.
REQ-014 SHALL have port m_axis_src, output, 2, index of the granted source.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse per completed frame.
REQ-016 SHALL have port frame_beats, output, 15, beat count of the last completed frame.
REQ-017 SHALL have port trunc_err, output, 1, sticky flag for a forced frame end.
REQ-018 SHALL have port err_clr, input, 1, clears trunc_err.

Function
REQ-019 SHALL implement states IDLE and BUSY; the grant index and state SHALL be registered.
REQ-020 In IDLE with enable=1 and any s_axis_vld, the block SHALL grant by round-robin starting at (last_grant+1) mod NUM_SRC, then enter BUSY on the next edge. The grant decision SHALL take 1 cycle.
REQ-021 In IDLE, all s_axis_rdy SHALL be 0 and m_axis_vld SHALL be 0.
REQ-022 In BUSY with grant g: m_axis_vld=s_axis_vld[g]; m_axis_data and m_axis_strb SHALL be combinational copies of source g; s_axis_rdy[g]=m_axis_rdy; all other rdy SHALL be 0.
REQ-023 A beat SHALL transfer when m_axis_vld & m_axis_rdy. beat_cnt SHALL count transferred beats in the current frame, starting from 0.
REQ-024 m_axis_last SHALL equal s_axis_last[g] OR (beat_cnt == MAX_BEATS-1).
REQ-025 A transfer with m_axis_last=1 SHALL end the frame: the next state SHALL be IDLE, frame_done SHALL pulse for the following cycle, frame_beats SHALL be loaded with beat_cnt+1, and beat_cnt SHALL clear.
REQ-026 If the forced last fires while s_axis_last[g]=0, trunc_err SHALL set. Subsequent beats from g SHALL start a new frame after re-arbitration.
REQ-027 err_clr SHALL clear trunc_err. A set event in the same cycle SHALL take priority over err_clr.
REQ-028 enable=0 during BUSY SHALL NOT abort the frame. It SHALL only block the next grant.
REQ-029 Frames SHALL be separated by at least one IDLE cycle. No source SHALL be granted twice in a row while another source is valid in IDLE.
REQ-030 m_axis_src SHALL hold g in BUSY and the last grant in IDLE.
REQ-031 beat_cnt SHALL be 15 bits and SHALL never exceed MAX_BEATS-1.

Reset
REQ-032 On rst: state=IDLE, last_grant=NUM_SRC-1 (so source 0 wins first), beat_cnt=0, m_axis_src=0, frame_beats=0, frame_done=0, trunc_err=0. All rdy and vld outputs SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame immediately, with no frame_done. After release, arbitration SHALL restart from source 0.

Verification
REQ-034 Sources 0, 1, and 2 are all valid, each sending 4-beat frames, with m_axis_rdy=1 -> grants in order 0, 1, 2, 0. Each frame takes 4 beats plus 1 IDLE cycle, and frame_beats=4 on each frame_done.
REQ-035 Only source 1 sends a 3-beat frame, and m_axis_rdy toggles every cycle -> there are 3 transfers and no data loss. m_axis_data matches source 1 in order, and s_axis_rdy[0] and s_axis_rdy[2] stay 0 throughout.
REQ-036 Source 0 streams 16385 beats with no last -> m_axis_last asserts on beat 16384, trunc_err=1, and frame_beats=16384. The remaining beat arrives in a new 1-beat frame once last is set.
REQ-037 enable drops at beat 2 of a 5-beat frame -> the frame completes with 5 beats, then the block stays in IDLE with no grant until enable=1.
REQ-038 rst pulses at beat 3 of a frame -> outputs immediately take the reset values of REQ-032, no frame_done occurs, and the next grant goes to source 0.
REQ-039 trunc_err set and err_clr asserted in the same cycle -> trunc_err stays 1. A later err_clr alone -> trunc_err reads 0 on the next cycle.

Source files
------------

// File: rtl/gyro_src_arb_if.sv
// Bundle of stream, control and status signals around the gyro source arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface gyro_src_arb_if #(
  parameter int NUM_SRC = 3
);
  logic                    enable;
  logic [NUM_SRC-1:0]      s_axis_vld;
  logic [NUM_SRC*48-1:0]   s_axis_data;
  logic [NUM_SRC*6-1:0]    s_axis_strb;
  logic [NUM_SRC-1:0]      s_axis_last;
  logic [NUM_SRC-1:0]      s_axis_rdy;
  logic                    m_axis_vld;
  logic [47:0]             m_axis_data;
  logic [5:0]              m_axis_strb;
  logic                    m_axis_last;
  logic                    m_axis_rdy;
  logic [1:0]              m_axis_src;
  logic                    frame_done;
  logic [14:0]             frame_beats;
  logic                    trunc_err;
  logic                    err_clr;

  modport master (
    input  enable, s_axis_vld, s_axis_data, s_axis_strb, s_axis_last,
    input  m_axis_rdy, err_clr,
    output s_axis_rdy, m_axis_vld, m_axis_data, m_axis_strb, m_axis_last,
    output m_axis_src, frame_done, frame_beats, trunc_err
  );

  modport slave (
    output enable, s_axis_vld, s_axis_data, s_axis_strb, s_axis_last,
    output m_axis_rdy, err_clr,
    input  s_axis_rdy, m_axis_vld, m_axis_data, m_axis_strb, m_axis_last,
    input  m_axis_src, frame_done, frame_beats, trunc_err
  );
endinterface

// File: rtl/gyro_src_arb.sv
// Round-robin frame arbiter: grants one 48-bit gyro stream at a time to the packer,
// caps frames at MAX_BEATS beats and flags truncated frames.
module gyro_src_arb #(
  parameter int NUM_SRC   = 3,
  parameter int MAX_BEATS = 16384
) (
  input  logic           clk,
  input  logic           rst,
  gyro_src_arb_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [14:0] LAST_BEAT = 15'(MAX_BEATS - 1);
  localparam logic [1:0]  LAST_SRC  = 2'(NUM_SRC - 1);

  state_t              state_q, state_d;
  logic [1:0]          src_q, src_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic [14:0]         beat_cnt_q, beat_cnt_d;
  logic [14:0]         frame_beats_q, frame_beats_d;
  logic                frame_done_q, frame_done_d;
  logic                trunc_err_q, trunc_err_d;

  logic                busy_s;
  logic [2*NUM_SRC-1:0] dbl_vld_s;
  logic [2*NUM_SRC-1:0] shf_vld_s;
  logic [NUM_SRC-1:0]  rot_vld_s;
  logic [1:0]          win_idx_s;
  logic                win_vld_s;
  logic                sel_vld_s;
  logic                sel_last_s;
  logic [47:0]         sel_data_s;
  logic [5:0]          sel_strb_s;
  logic [NUM_SRC-1:0]  s_rdy_s;
  logic                forced_s;
  logic                m_vld_s;
  logic                m_last_s;
  logic                xfer_s;
  logic                trunc_set_s;

  assign busy_s      = (state_q == ST_BUSY);
  assign forced_s    = (beat_cnt_q == LAST_BEAT);
  assign m_vld_s     = busy_s & sel_vld_s;
  assign m_last_s    = busy_s & (sel_last_s | forced_s);
  assign xfer_s      = m_vld_s & bus.m_axis_rdy;
  assign trunc_set_s = xfer_s & forced_s & ~sel_last_s;

  // Round-robin pick: rotate valids so the source after last_grant sits at bit 0.
  always_comb begin
    logic [2:0] sum_v;
    sum_v     = 3'd0;
    dbl_vld_s = {bus.s_axis_vld, bus.s_axis_vld};
    shf_vld_s = dbl_vld_s >> (3'(last_grant_q) + 3'd1);
    rot_vld_s = shf_vld_s[NUM_SRC-1:0];
    win_idx_s = 2'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      sum_v     = 3'(last_grant_q) + 3'd1 + 3'(k);
      sum_v     = (sum_v >= 3'(NUM_SRC)) ? (sum_v - 3'(NUM_SRC)) : sum_v;
      win_idx_s = rot_vld_s[k] ? sum_v[1:0] : win_idx_s;
    end
    win_vld_s = |bus.s_axis_vld;
  end

  // AND-OR mux of the granted source onto the downstream stream and ready fan-out.
  always_comb begin
    logic hit_v;
    hit_v      = 1'b0;
    sel_vld_s  = 1'b0;
    sel_last_s = 1'b0;
    sel_data_s = 48'h0;
    sel_strb_s = 6'h0;
    s_rdy_s    = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_v      = (src_q == 2'(i));
      sel_vld_s  = sel_vld_s  | (hit_v & bus.s_axis_vld[i]);
      sel_last_s = sel_last_s | (hit_v & bus.s_axis_last[i]);
      sel_data_s = sel_data_s | (bus.s_axis_data[i*48 +: 48] & {48{hit_v}});
      sel_strb_s = sel_strb_s | (bus.s_axis_strb[i*6 +: 6] & {6{hit_v}});
      s_rdy_s[i] = hit_v & busy_s & bus.m_axis_rdy;
    end
  end

  // Next-state logic: grant in IDLE, count beats and close frames in BUSY.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    frame_beats_d = frame_beats_q;
    frame_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable && win_vld_s) begin
          state_d      = ST_BUSY;
          src_d        = win_idx_s;
          last_grant_d = win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // enable is deliberately ignored here: an open frame always runs to its end.
        if (xfer_s && m_last_s) begin
          state_d       = ST_IDLE;
          frame_done_d  = 1'b1;
          frame_beats_d = beat_cnt_q + 15'd1;
          beat_cnt_d    = 15'd0;
        end else if (xfer_s) begin
          beat_cnt_d = beat_cnt_q + 15'd1;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = 15'd0;
      end
    endcase
    // A truncation in the same cycle as err_clr must not be lost.
    trunc_err_d = trunc_set_s ? 1'b1 : (bus.err_clr ? 1'b0 : trunc_err_q);
  end

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      src_q         <= 2'd0;
      last_grant_q  <= LAST_SRC;
      beat_cnt_q    <= 15'd0;
      frame_beats_q <= 15'd0;
      frame_done_q  <= 1'b0;
      trunc_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      frame_beats_q <= frame_beats_d;
      frame_done_q  <= frame_done_d;
      trunc_err_q   <= trunc_err_d;
    end
  end

  assign bus.s_axis_rdy  = s_rdy_s;
  assign bus.m_axis_vld  = m_vld_s;
  assign bus.m_axis_data = sel_data_s;
  assign bus.m_axis_strb = sel_strb_s;
  assign bus.m_axis_last = m_last_s;
  assign bus.m_axis_src  = src_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_beats = frame_beats_q;
  assign bus.trunc_err   = trunc_err_q;

endmodule

// File: tb/tb_gyro_src_arb.sv
// Directed bench for gyro_src_arb: scripted per-source frame model, per-feature tasks.
module tb_gyro_src_arb;
  localparam int NUM_SRC   = 3;
  localparam int MAX_BEATS = 16384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gyro_src_arb_if #(.NUM_SRC(NUM_SRC)) bus ();
  gyro_src_arb #(.NUM_SRC(NUM_SRC), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int src_len[NUM_SRC];
  int src_total[NUM_SRC];
  int src_sent[NUM_SRC];

  function automatic logic [53:0] exp_beat(int s, int n);
    return {8'(s), 40'(n), 6'(n + s)};
  endfunction

  task automatic set_src(int s, int len, int total);
    src_len[s]   = len;
    src_total[s] = total;
    src_sent[s]  = 0;
  endtask

  // Present each source's next beat; last marks frame boundaries or end of stream.
  task automatic drive_sources();
    logic [53:0] b;
    for (int s = 0; s < NUM_SRC; s++) begin
      b = exp_beat(s, src_sent[s]);
      bus.s_axis_vld[s]          = (src_sent[s] < src_total[s]);
      bus.s_axis_data[s*48 +: 48] = b[53:6];
      bus.s_axis_strb[s*6 +: 6]   = b[5:0];
      bus.s_axis_last[s] = (src_sent[s] == src_total[s] - 1) ||
                           ((src_len[s] != 0) && (src_sent[s] % src_len[s] == src_len[s] - 1));
    end
  endtask

  task automatic tick();
    logic [NUM_SRC-1:0] xf;
    xf = bus.s_axis_rdy & bus.s_axis_vld;
    @(posedge clk);
    #1;
    for (int s = 0; s < NUM_SRC; s++) if (xf[s]) src_sent[s]++;
    drive_sources();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.m_axis_rdy = 1'b0; bus.err_clr = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) set_src(s, 0, 0);
    drive_sources();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.m_axis_vld, bus.m_axis_last, bus.s_axis_rdy, bus.frame_done, bus.trunc_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b need 0000000", {bus.m_axis_vld, bus.m_axis_last, bus.s_axis_rdy, bus.frame_done, bus.trunc_err});
    end
    n_tests++;
    if (bus.m_axis_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d need 0", bus.m_axis_src); end
    n_tests++;
    if (bus.frame_beats !== 15'd0) begin n_fail++; $display("FAIL reset_beats: got %0d need 0", bus.frame_beats); end
    rst = 1'b0; bus.enable = 1'b1; bus.m_axis_rdy = 1'b1;
    #1;
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    int nd = 0, last_done = 0, cyc = 0, s;
    set_src(0, 4, 8); set_src(1, 4, 4); set_src(2, 4, 4);
    drive_sources(); #1;
    while (nd < 4 && cyc < 80) begin
      if (bus.m_axis_vld && bus.m_axis_rdy) begin
        s = int'(bus.m_axis_src);
        n_tests++;
        if ({bus.m_axis_data, bus.m_axis_strb} !== exp_beat(s, src_sent[s])) begin
          n_fail++; $display("FAIL rr_data: got %h need %h", {bus.m_axis_data, bus.m_axis_strb}, exp_beat(s, src_sent[s]));
        end
      end
      if (bus.frame_done) begin
        n_tests++;
        if (bus.frame_beats !== 15'd4) begin n_fail++; $display("FAIL rr_beats: got %0d need 4", bus.frame_beats); end
        n_tests++;
        if (bus.m_axis_src !== 2'(order[nd])) begin n_fail++; $display("FAIL rr_order: frame %0d got %0d need %0d", nd, bus.m_axis_src, order[nd]); end
        if (nd > 0) begin
          n_tests++;
          if (cyc - last_done != 5) begin n_fail++; $display("FAIL rr_period: got %0d need 5", cyc - last_done); end
        end
        last_done = cyc;
        nd++;
      end
      tick(); cyc++;
    end
    n_tests++;
    if (nd != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d frames need 4", nd); end
    n_tests++;
    if (bus.trunc_err !== 1'b0) begin n_fail++; $display("FAIL rr_trunc: got %b need 0", bus.trunc_err); end
  endtask

  task automatic test_rdy_toggle();
    int nx = 0, cyc = 0;
    bit done = 1'b0, leak = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) set_src(s, 0, 0);
    set_src(1, 3, 3);
    drive_sources();
    while (!done && cyc < 40) begin
      bus.m_axis_rdy = (cyc % 2 == 1);
      #1;
      if (bus.s_axis_rdy[0] || bus.s_axis_rdy[2]) leak = 1'b1;
      if (bus.m_axis_vld && bus.m_axis_rdy) begin
        n_tests++;
        if ({bus.m_axis_data, bus.m_axis_strb} !== exp_beat(1, nx)) begin
          n_fail++; $display("FAIL tog_data: beat %0d got %h need %h", nx, {bus.m_axis_data, bus.m_axis_strb}, exp_beat(1, nx));
        end
        nx++;
      end
      if (bus.frame_done) begin
        done = 1'b1;
        n_tests++;
        if (bus.frame_beats !== 15'd3) begin n_fail++; $display("FAIL tog_beats: got %0d need 3", bus.frame_beats); end
      end
      tick(); cyc++;
    end
    n_tests++;
    if (nx != 3 || !done) begin n_fail++; $display("FAIL tog_count: got %0d xfers done=%0d need 3 done=1", nx, done); end
    n_tests++;
    if (leak) begin n_fail++; $display("FAIL tog_leak: got rdy on 0/2 need none"); end
    bus.m_axis_rdy = 1'b1;
    #1;
  endtask

  // Also exercises err_clr colliding with the truncation set.
  task automatic test_truncation();
    int nx = 0, last_at = 0, cyc = 0, nd = 0;
    set_src(1, 0, 0);
    set_src(0, 0, MAX_BEATS + 1);
    drive_sources(); #1;
    while (nd < 2 && cyc < MAX_BEATS + 100) begin
      bus.err_clr = 1'b0;
      if (bus.m_axis_vld && bus.m_axis_rdy) begin
        nx++;
        if (bus.m_axis_last && last_at == 0) begin
          last_at = nx;
          bus.err_clr = 1'b1;
        end
      end
      if (bus.frame_done) begin
        nd++;
        n_tests++;
        if (nd == 1 && bus.frame_beats !== 15'(MAX_BEATS)) begin n_fail++; $display("FAIL trunc_beats: got %0d need %0d", bus.frame_beats, MAX_BEATS); end
        if (nd == 2 && bus.frame_beats !== 15'd1) begin n_fail++; $display("FAIL trunc_rest: got %0d need 1", bus.frame_beats); end
        if (nd == 1) begin
          n_tests++;
          if (bus.trunc_err !== 1'b1) begin n_fail++; $display("FAIL trunc_prio: got %b need 1", bus.trunc_err); end
        end
      end
      tick(); cyc++;
    end
    bus.err_clr = 1'b0;
    n_tests++;
    if (last_at != MAX_BEATS) begin n_fail++; $display("FAIL trunc_last: got beat %0d need %0d", last_at, MAX_BEATS); end
    n_tests++;
    if (nx != MAX_BEATS + 1 || nd != 2) begin n_fail++; $display("FAIL trunc_total: got %0d beats %0d frames need %0d/2", nx, nd, MAX_BEATS + 1); end
  endtask

  task automatic test_err_clr();
    n_tests++;
    if (bus.trunc_err !== 1'b1) begin n_fail++; $display("FAIL clr_pre: got %b need 1", bus.trunc_err); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.trunc_err !== 1'b0) begin n_fail++; $display("FAIL clr_post: got %b need 0", bus.trunc_err); end
  endtask

  task automatic test_enable();
    int nx = 0, cyc = 0;
    bit done = 1'b0, bad = 1'b0;
    set_src(0, 0, 0);
    set_src(2, 5, 10);
    drive_sources(); #1;
    while (!done && cyc < 40) begin
      if (bus.m_axis_vld && bus.m_axis_rdy) begin
        nx++;
        if (nx == 2) bus.enable = 1'b0;
      end
      if (bus.frame_done) begin
        done = 1'b1;
        n_tests++;
        if (bus.frame_beats !== 15'd5) begin n_fail++; $display("FAIL en_beats: got %0d need 5", bus.frame_beats); end
      end
      tick(); cyc++;
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.m_axis_vld || (bus.s_axis_rdy != 3'b000) || bus.m_axis_src !== 2'd2) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad || !done) begin n_fail++; $display("FAIL en_hold: got grant while disabled (done=%0d) need none", done); end
    bus.enable = 1'b1;
    tick();
    n_tests++;
    if ({bus.m_axis_vld, bus.m_axis_src} !== 3'b110) begin n_fail++; $display("FAIL en_resume: got %b need 110", {bus.m_axis_vld, bus.m_axis_src}); end
    done = 1'b0; cyc = 0;
    while (!done && cyc < 20) begin
      if (bus.frame_done) done = 1'b1;
      tick(); cyc++;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL en_drain: got no frame_done need one"); end
  endtask

  task automatic test_reset_midframe();
    int cyc = 0;
    bit fd_seen = 1'b0;
    set_src(2, 0, 0);
    set_src(1, 8, 8);
    drive_sources(); #1;
    while (src_sent[1] < 3 && cyc < 20) begin tick(); cyc++; end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.m_axis_vld, bus.m_axis_last, bus.s_axis_rdy, bus.frame_done, bus.trunc_err, bus.m_axis_src} !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ctl: got %b need 0", {bus.m_axis_vld, bus.m_axis_last, bus.s_axis_rdy, bus.frame_done, bus.trunc_err, bus.m_axis_src});
    end
    n_tests++;
    if (bus.frame_beats !== 15'd0) begin n_fail++; $display("FAIL rst_mid_beats: got %0d need 0", bus.frame_beats); end
    tick();
    if (bus.frame_done) fd_seen = 1'b1;
    rst = 1'b0;
    set_src(0, 2, 2); set_src(1, 2, 2); set_src(2, 2, 2);
    drive_sources(); #1;
    if (bus.frame_done) fd_seen = 1'b1;
    tick();
    if (bus.frame_done) fd_seen = 1'b1;
    n_tests++;
    if ({bus.m_axis_vld, bus.m_axis_src} !== 3'b100) begin n_fail++; $display("FAIL rst_mid_regrant: got %b need 100", {bus.m_axis_vld, bus.m_axis_src}); end
    n_tests++;
    if (fd_seen) begin n_fail++; $display("FAIL rst_mid_done: got frame_done need none"); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rdy_toggle();
    test_truncation();
    test_err_clr();
    test_enable();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
